// File: rtl/lu_serial_seq.sv
// Bit-serial sequencer around the 1-bit selectable logic cell: walks two WIDTH-bit
// operands LSB first and assembles AND/NAND (sa) and OR/NOR (sb) results.
module lu_cell (
  input  logic x,
  input  logic y,
  input  logic key,
  output logic ya,
  output logic yb
);
  assign ya = key ? ~(x & y) : (x & y);
  assign yb = key ? ~(x | y) : (x | y);
endmodule

module lu_serial_seq #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             key,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sa,
  output logic [WIDTH-1:0] sb,
  output logic [IDXW-1:0]  bit_idx
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic             load, step;
  logic [WIDTH-1:0] a_lat, b_lat;
  logic             key_lat;
  logic             bit_a, bit_b;

  lu_cell u_cell (
    .x   (a_lat[bit_idx]),
    .y   (b_lat[bit_idx]),
    .key (key_lat),
    .ya  (bit_a),
    .yb  (bit_b)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (bit_idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        // DONE accepts a new start just like IDLE, giving back-to-back operation
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sa      <= '0;
      sb      <= '0;
      bit_idx <= '0;
      a_lat   <= '0;
      b_lat   <= '0;
      key_lat <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
      if (load) begin
        a_lat   <= a;
        b_lat   <= b;
        key_lat <= key;
        sa      <= '0;
        sb      <= '0;
        bit_idx <= '0;
      end else if (step) begin
        sa[bit_idx] <= bit_a;
        sb[bit_idx] <= bit_b;
        bit_idx     <= (bit_idx == LAST) ? '0 : bit_idx + IDXW'(1);
      end
    end
  end
endmodule

// File: tb/tb_lu_serial_seq.sv
// Directed bench for lu_serial_seq: reset, AND/OR and NAND/NOR runs, input
// disturbance during RUN, back-to-back operation and asynchronous abort.
module tb_lu_serial_seq;
  localparam int WIDTH = 8;
  localparam int IDXW  = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             start = 1'b0;
  logic             key = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done;
  logic [WIDTH-1:0] sa, sb;
  logic [IDXW-1:0]  bit_idx;

  int total = 0;
  int bad   = 0;

  lu_serial_seq #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .key     (key),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .sa      (sa),
    .sb      (sb),
    .bit_idx (bit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] esa, input logic [7:0] esb);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".sa"}, 32'(sa), 32'(esa));
    chk({tag, ".sb"}, 32'(sb), 32'(esb));
    chk({tag, ".idx"}, 32'(bit_idx), 32'd0);
  endtask

  // One full operation; disturb changes operands and pulses start mid-run.
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tk, input logic [7:0] esa, input logic [7:0] esb,
                       input bit disturb);
    logic [7:0] m;
    a = ta; b = tb; key = tk; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".e0.busy"}, 32'(busy), 32'd1);
    chk({tag, ".e0.sa"}, 32'(sa), 32'd0);
    for (int i = 1; i <= WIDTH; i++) begin
      if (disturb && i == 3) begin
        a = 8'hFF; b = 8'hFF; key = 1'b0; start = 1'b1;
      end
      if (disturb && i == 4) start = 1'b0;
      tick();
      m = 8'((9'(1) << i) - 9'(1));
      chk($sformatf("%s.b%0d.sa", tag, i), 32'(sa), 32'(esa & m));
      chk($sformatf("%s.b%0d.sb", tag, i), 32'(sb), 32'(esb & m));
      chk($sformatf("%s.b%0d.idx", tag, i), 32'(bit_idx), 32'(i % WIDTH));
      chk($sformatf("%s.b%0d.busy", tag, i), 32'(busy), (i < WIDTH) ? 32'd1 : 32'd0);
      chk($sformatf("%s.b%0d.done", tag, i), 32'(done), (i < WIDTH) ? 32'd0 : 32'd1);
    end
    tick();
    chk_idle({tag, ".after"}, esa, esb);
  endtask

  initial begin
    // 1. reset then idle
    #1 reset_n = 1'b0;
    #1 chk_idle("rst.async", 8'h00, 8'h00);
    tick(); tick();
    chk_idle("rst.held", 8'h00, 8'h00);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle($sformatf("idle%0d", i), 8'h00, 8'h00);
    end

    // 2. AND/OR, 3. NAND/NOR with per-bit partial checks
    do_op("andor", 8'hCA, 8'h5C, 1'b0, 8'h48, 8'hDE, 1'b0);
    do_op("nandnor", 8'hCA, 8'h5C, 1'b1, 8'hB7, 8'h21, 1'b0);
    // 4. inputs and start disturbed during RUN
    do_op("disturb", 8'hCA, 8'h5C, 1'b1, 8'hB7, 8'h21, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("disturb.hold%0d", i), 8'hB7, 8'h21);
    end

    // 5. back-to-back with start held high
    a = 8'hFF; b = 8'h0F; key = 1'b0; start = 1'b1;
    tick();
    chk("b2b.e0.busy", 32'(busy), 32'd1);
    for (int op = 0; op < 3; op++) begin
      for (int i = 1; i <= WIDTH; i++) begin
        tick();
        chk($sformatf("b2b%0d.b%0d.busy", op, i), 32'(busy), (i < WIDTH) ? 32'd1 : 32'd0);
        chk($sformatf("b2b%0d.b%0d.done", op, i), 32'(done), (i < WIDTH) ? 32'd0 : 32'd1);
      end
      chk($sformatf("b2b%0d.sa", op), 32'(sa), 32'h0F);
      chk($sformatf("b2b%0d.sb", op), 32'(sb), 32'hFF);
      if (op < 2) begin
        tick();
        chk($sformatf("b2b%0d.restart.busy", op), 32'(busy), 32'd1);
        chk($sformatf("b2b%0d.restart.done", op), 32'(done), 32'd0);
        chk($sformatf("b2b%0d.restart.sa", op), 32'(sa), 32'h00);
      end
    end
    start = 1'b0;
    tick();
    chk_idle("b2b.end", 8'h0F, 8'hFF);

    // 6. asynchronous reset after three bits
    a = 8'hCA; b = 8'h5C; key = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("abort.pre.sa", 32'(sa), 32'h07);
    chk("abort.pre.idx", 32'(bit_idx), 32'd3);
    #2 reset_n = 1'b0;
    #1 chk_idle("abort.async", 8'h00, 8'h00);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_idle($sformatf("abort.idle%0d", i), 8'h00, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lu_serial_seq.md
Name: lu_serial_seq

Overview:
- Bit-serial sequencer for the team's 1-bit selectable logic unit: AND/NAND on result A, OR/NOR on result B, chosen by a key.
- Accepts two WIDTH-bit operands and a key on a start pulse.
- Drives one bit pair per clock through the 1-bit logic path, LSB first, and assembles two WIDTH-bit results.
- Signals busy/done to the surrounding control.
- Sits between a host (register file/testbench) and the 1-bit logic unit datapath, which it instantiates internally.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
IDXW, 3, width of bit index counter; must satisfy 2**IDXW >= WIDTH

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request to begin; sampled on rising clk
key  input  1  function select: 0 = AND/OR, 1 = NAND/NOR
a  input  WIDTH  operand A
b  input  WIDTH  operand B
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when results are complete
sa  output  WIDTH  result A (key=0: a AND b; key=1: a NAND b)
sb  output  WIDTH  result B (key=0: a OR b; key=1: a NOR b)
bit_idx  output  IDXW  index of the bit processed on the next RUN edge

Behaviour:
- Reset (asynchronous, active-low, one clock): reset_n low forces state=IDLE, busy=0, done=0, sa=0, sb=0, bit_idx=0, and clears the internal operand/key latches, regardless of clk. Reset asserted mid-RUN aborts the operation with no partial-result retention.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E: latch a, b, key into internal registers; sa=0; sb=0; bit_idx=0; busy=1; go to RUN.
  - start=0: hold all outputs. Results of the last operation remain valid.
- RUN, each edge:
  - Feed latched a[bit_idx], b[bit_idx], latched key to the 1-bit logic unit.
  - Write its two outputs into sa[bit_idx] and sb[bit_idx]; bit_idx increments.
  - At the edge that writes bit WIDTH-1: go to DONE, busy=0, done=1, bit_idx wraps to 0.
  - start is ignored in RUN. a, b, key may change freely in RUN without affecting the result.
- DONE:
  - Lasts exactly one cycle; done=1 during it. Next edge clears done.
  - start=1 at that edge: accepted exactly as in IDLE (back-to-back operation, sa/sb cleared, busy=1, state RUN).
  - Otherwise go to IDLE.
- Latency: start sampled at edge E; bit i written at edge E+1+i; done high from edge E+WIDTH to E+WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- Key polarity matches the 1-bit logic unit: key=0 selects the AND/OR path, key=1 the NAND/NOR path. key is latched once per operation, never per bit.
- busy and done are never high simultaneously. done is never high for more than one consecutive cycle.
- sa/sb are registered outputs. During RUN, bits above bit_idx read 0.

Test Plan:
1. Reset then idle: reset_n=0 for 2 cycles, release, start=0 for 5 cycles -> busy=0, done=0, sa=0x00, sb=0x00, bit_idx=0 throughout.
2. AND/OR, WIDTH=8: a=0xCA, b=0x5C, key=0, start pulsed at edge E -> busy high E..E+8, done high one cycle after edge E+8, sa=0x48, sb=0xDE held afterwards.
3. NAND/NOR: a=0xCA, b=0x5C, key=1 -> sa=0xB7, sb=0x21 at done. Check mid-run after edge E+4: sa=0x07, sb=0x01, bit_idx=4.
4. Operand/start stability: during RUN change a=0xFF, b=0xFF, key=0, pulse start -> result unaffected (sa=0xB7, sb=0x21), no restart, single done pulse.
5. Back-to-back: hold start=1 continuously with a=0xFF, b=0x0F, key=0 -> done every 9 cycles, sa=0x0F, sb=0xFF each time, busy low only in DONE cycles.
6. Reset mid-operation: assert reset_n=0 asynchronously (between edges) after 3 bits processed -> immediately busy=0, sa=0, sb=0, bit_idx=0. After release with start=0, stays IDLE and no done pulse occurs.
